seg7_scan_decoder: RTL and testbench

//  Inverse of our hex-to-7-segment encoder: sniffs a time-multiplexed 7-segment display bus
//  (segment lines + one-hot digit enables), decodes each held pattern back to a 4-bit hex nibble,

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_pattern_decode.sv | 35 +++
 rtl/seg7_scan_decoder.sv | 117 +++++++++++
 tb/tb_seg7_scan_decoder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Segment patterns shared by the hex-to-7-segment encoder and the scan read-back decoder.
// Bit order is {a,b,c,d,e,f,g}, active-high.
package seg7_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_HEX_0 = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_HEX_1 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_HEX_2 = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_HEX_3 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_HEX_4 = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_HEX_5 = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_HEX_6 = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_HEX_7 = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_HEX_8 = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_HEX_9 = 7'b1111011;
    localparam logic [SEG_W-1:0] SEG_HEX_A = 7'b1110111;
    localparam logic [SEG_W-1:0] SEG_HEX_B = 7'b0011111;
    localparam logic [SEG_W-1:0] SEG_HEX_C = 7'b1001110;
    localparam logic [SEG_W-1:0] SEG_HEX_D = 7'b0111101;
    localparam logic [SEG_W-1:0] SEG_HEX_E = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_HEX_F = 7'b1000111;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex encoder: maps a segment pattern back to its nibble.
// Anything that is not one of the sixteen encoder outputs is flagged illegal and reads as 0.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic [3:0]       nibble,
    output logic             illegal
);

    always_comb begin
        nibble  = 4'h0;
        illegal = 1'b0;
        case (seg)
            SEG_HEX_0: nibble = 4'h0;
            SEG_HEX_1: nibble = 4'h1;
            SEG_HEX_2: nibble = 4'h2;
            SEG_HEX_3: nibble = 4'h3;
            SEG_HEX_4: nibble = 4'h4;
            SEG_HEX_5: nibble = 4'h5;
            SEG_HEX_6: nibble = 4'h6;
            SEG_HEX_7: nibble = 4'h7;
            SEG_HEX_8: nibble = 4'h8;
            SEG_HEX_9: nibble = 4'h9;
            SEG_HEX_A: nibble = 4'hA;
            SEG_HEX_B: nibble = 4'hB;
            SEG_HEX_C: nibble = 4'hC;
            SEG_HEX_D: nibble = 4'hD;
            SEG_HEX_E: nibble = 4'hE;
            SEG_HEX_F: nibble = 4'hF;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Sniffs a multiplexed 7-segment bus, debounces each digit dwell and assembles
// the decoded nibbles into a full NUM_DIGITS-digit word once every digit has been seen.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SEG_W-1:0]        seg,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    value_valid,
    output logic                    frame_done,
    output logic                    onehot_err
);

    localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [SEG_W-1:0]        seg_p1;
    logic [NUM_DIGITS-1:0]   dig_en_p1;
    logic [CNT_W-1:0]        cnt_p1;
    logic                    dwell_p1;
    logic [4*NUM_DIGITS-1:0] shadow_p1;
    logic [NUM_DIGITS-1:0]   shadow_err_p1;
    logic [NUM_DIGITS-1:0]   mask_p1;

    logic [3:0]              nibble;
    logic                    illegal;
    logic                    multi;
    logic                    good;
    logic                    same;
    logic                    dwell_eff;
    logic                    capture;
    logic                    frame_complete;
    logic [CNT_W-1:0]        cnt_next;
    logic [4*NUM_DIGITS-1:0] shadow_next;
    logic [NUM_DIGITS-1:0]   shadow_err_next;
    logic [NUM_DIGITS-1:0]   mask_next;

    seg7_pattern_decode u_decode (
        .seg     (seg),
        .nibble  (nibble),
        .illegal (illegal)
    );

    // Stage 0: classify the current sample against the previous one
    always_comb begin
        multi     = (dig_en & (dig_en - NUM_DIGITS'(1))) != '0;
        good      = (dig_en != '0) && !multi;
        same      = ({seg, dig_en} == {seg_p1, dig_en_p1});
        // A changed or bad sample starts a fresh dwell, so the old capture flag no longer applies.
        dwell_eff = good && same && dwell_p1;

        if (!good) begin
            cnt_next = '0;
        end else if (!same) begin
            cnt_next = CNT_W'(1);
        end else if (cnt_p1 == CNT_MAX) begin
            cnt_next = cnt_p1;
        end else begin
            cnt_next = cnt_p1 + CNT_W'(1);
        end

        capture         = good && (cnt_next == CNT_MAX) && !dwell_eff;
        shadow_next     = shadow_p1;
        shadow_err_next = shadow_err_p1;
        mask_next       = mask_p1;
        if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (dig_en[i]) begin
                    shadow_next[4*i +: 4] = nibble;
                    shadow_err_next[i]    = illegal;
                    mask_next[i]          = 1'b1;
                end
            end
        end
        frame_complete = capture && (&mask_next);
    end

    // Stage 1: sample history, dwell tracking, shadow frame and published outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_p1        <= '0;
            dig_en_p1     <= '0;
            cnt_p1        <= '0;
            dwell_p1      <= 1'b0;
            shadow_p1     <= '0;
            shadow_err_p1 <= '0;
            mask_p1       <= '0;
            value         <= '0;
            digit_err     <= '0;
            value_valid   <= 1'b0;
            frame_done    <= 1'b0;
            onehot_err    <= 1'b0;
        end else begin
            seg_p1        <= seg;
            dig_en_p1     <= dig_en;
            cnt_p1        <= cnt_next;
            dwell_p1      <= capture || dwell_eff;
            shadow_p1     <= shadow_next;
            shadow_err_p1 <= shadow_err_next;
            mask_p1       <= frame_complete ? '0 : mask_next;
            frame_done    <= frame_complete;
            onehot_err    <= multi;
            if (frame_complete) begin
                value       <= shadow_next;
                digit_err   <= shadow_err_next;
                value_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: expected frames queued as scans are driven,
// popped and compared whenever frame_done is seen.
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = '0;
    logic [3:0]  dig_en = '0;
    logic [15:0] value;
    logic [3:0]  digit_err;
    logic        value_valid;
    logic        frame_done;
    logic        onehot_err;

    typedef struct {
        logic [15:0] v;
        logic [3:0]  e;
    } frame_t;

    frame_t sb[$];
    int total = 0;
    int bad = 0;
    int fd_seen = 0;
    int oh_seen = 0;
    logic exp_oh = 1'b0;

    localparam logic [6:0] P0 = 7'b1111110, P1 = 7'b0110000, P2 = 7'b1101101,
                           P3 = 7'b1111001, P4 = 7'b0110011, P5 = 7'b1011011,
                           P6 = 7'b1011111, P7 = 7'b1110000, P8 = 7'b1111111,
                           P9 = 7'b1111011, PA = 7'b1110111, PB = 7'b0011111,
                           PC = 7'b1001110, PD = 7'b0111101, PE = 7'b1001111,
                           PF = 7'b1000111;

    seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .dig_en      (dig_en),
        .value       (value),
        .digit_err   (digit_err),
        .value_valid (value_valid),
        .frame_done  (frame_done),
        .onehot_err  (onehot_err)
    );

    always #5 clk = ~clk;

    // Reference for onehot_err: a pulse follows every sample with more than one enable set.
    always @(posedge clk or posedge rst) begin
        if (rst) exp_oh = 1'b0;
        else     exp_oh = ($countones(dig_en) > 1);
    end

    always @(negedge clk) begin
        if (!rst) begin
            total++;
            assert (onehot_err === exp_oh) else begin
                bad++;
                $error("FAIL onehot_err observed=%b expected=%b", onehot_err, exp_oh);
            end
            if (onehot_err) oh_seen++;
            if (frame_done) begin
                fd_seen++;
                total++;
                assert (sb.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_frame_done observed value=%h expected no frame", value);
                end
                if (sb.size() != 0) begin
                    frame_t f;
                    f = sb.pop_front();
                    total++;
                    assert (value === f.v) else begin
                        bad++;
                        $error("FAIL frame_value observed=%h expected=%h", value, f.v);
                    end
                    total++;
                    assert (digit_err === f.e) else begin
                        bad++;
                        $error("FAIL frame_err observed=%b expected=%b", digit_err, f.e);
                    end
                    total++;
                    assert (value_valid === 1'b1) else begin
                        bad++;
                        $error("FAIL frame_valid observed=%b expected=1", value_valid);
                    end
                end
            end
        end
    end

    task automatic drive(input logic [6:0] s, input logic [3:0] e, input int n);
        @(negedge clk);
        seg    = s;
        dig_en = e;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] v, input logic [3:0] e);
        frame_t f;
        f.v = v;
        f.e = e;
        sb.push_back(f);
    endtask

    task automatic settle();
        @(negedge clk);
        seg    = '0;
        dig_en = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int fd0;
        int oh0;
        repeat (3) @(negedge clk);
        check("reset_value", 32'(value), 32'h0);
        check("reset_valid", 32'(value_valid), 32'h0);
        rst = 1'b0;

        // Basic scan 0,1,A,F
        fd0 = fd_seen;
        drive(P0, 4'b0001, 4);
        drive(P1, 4'b0010, 4);
        drive(PA, 4'b0100, 4);
        push(16'hFA10, 4'b0000);
        drive(PF, 4'b1000, 4);
        settle();
        check("scan_fd_count", 32'(fd_seen - fd0), 32'd1);
        check("scan_value", 32'(value), 32'hFA10);
        check("scan_valid", 32'(value_valid), 32'h1);

        // Asynchronous reset between clock edges
        #2 rst = 1'b1;
        #1;
        check("async_rst_value", 32'(value), 32'h0);
        check("async_rst_err", 32'(digit_err), 32'h0);
        check("async_rst_valid", 32'(value_valid), 32'h0);
        check("async_rst_fd", 32'(frame_done), 32'h0);
        check("async_rst_oh", 32'(onehot_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Digit 1 interrupted before it is stable
        fd0 = fd_seen;
        drive(P5, 4'b0001, 4);
        drive(P3, 4'b0010, 3);
        drive(P7, 4'b0010, 2);
        drive(PC, 4'b0100, 4);
        drive(PE, 4'b1000, 4);
        settle();
        check("short_dwell_no_fd", 32'(fd_seen - fd0), 32'd0);
        check("short_dwell_valid", 32'(value_valid), 32'h0);
        push(16'hEC95, 4'b0000);
        drive(P9, 4'b0010, 4);
        settle();
        check("short_dwell_fd", 32'(fd_seen - fd0), 32'd1);

        // Illegal pattern on digit 2
        fd0 = fd_seen;
        drive(P8, 4'b0001, 4);
        drive(PB, 4'b0010, 4);
        drive(7'b0000001, 4'b0100, 4);
        push(16'h40B8, 4'b0100);
        drive(P4, 4'b1000, 4);
        settle();
        check("illegal_fd", 32'(fd_seen - fd0), 32'd1);
        check("illegal_nibble", 32'(value[11:8]), 32'h0);

        // Multiple enables, then a too-short one-hot dwell
        fd0 = fd_seen;
        drive(P6, 4'b0010, 4);
        drive(P1, 4'b0100, 4);
        drive(PD, 4'b1000, 4);
        oh0 = oh_seen;
        drive(P2, 4'b0011, 5);
        drive(P2, 4'b0001, 3);
        check("onehot_pulses", 32'(oh_seen - oh0), 32'd5);
        drive(P2, 4'b0000, 1);
        settle();
        check("onehot_no_capture", 32'(fd_seen - fd0), 32'd0);
        push(16'hD162, 4'b0000);
        drive(P2, 4'b0001, 4);
        settle();
        check("onehot_then_fd", 32'(fd_seen - fd0), 32'd1);

        // Reset discards partially captured digits
        fd0 = fd_seen;
        drive(P3, 4'b0001, 4);
        drive(P3, 4'b0010, 4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(PA, 4'b0100, 4);
        drive(PF, 4'b1000, 4);
        settle();
        check("rst_partial_no_fd", 32'(fd_seen - fd0), 32'd0);
        check("rst_partial_valid", 32'(value_valid), 32'h0);
        drive(P7, 4'b0001, 4);
        push(16'hFA87, 4'b0000);
        drive(P8, 4'b0010, 4);
        settle();
        check("rst_partial_fd", 32'(fd_seen - fd0), 32'd1);
        check("rst_partial_value", 32'(value), 32'hFA87);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
